// File: rtl/tx_frame_encoder.sv
// Checksum encoder and serial framer: {~popcount(din), din} sent as start, data LSB-first, [parity], stop.
// Optional even-parity bit after the data field is compiled in with TXENC_PARITY_EN.
module tx_frame_encoder #(
    parameter int DATA_W     = 7,
    parameter int CSUM_W     = 3,
    parameter int BIT_CYCLES = 1,
    localparam int FRAME_W   = DATA_W + CSUM_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DATA_W-1:0]  din,
    input  logic               din_valid,
    output logic               din_ready,
    output logic [FRAME_W-1:0] dout_word,
    output logic               dout_valid,
    output logic               tx_serial,
    output logic               tx_busy
);

    localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int IDX_W = $clog2(FRAME_W);

    if (CSUM_W < $clog2(DATA_W + 1)) begin : g_bad_csum
        $error("tx_frame_encoder: CSUM_W too narrow to hold the ones count of DATA_W");
    end

`ifdef TXENC_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [IDX_W-1:0]   idx, idx_d;
    logic [FRAME_W-1:0] word_d;
    logic               serial_d;
    logic               bit_last, idx_last, accept;

    function automatic logic [CSUM_W-1:0] ones_count(input logic [DATA_W-1:0] v);
        logic [CSUM_W-1:0] n;
        n = '0;
        for (int i = 0; i < DATA_W; i++) begin
            n = n + CSUM_W'(v[i]);
        end
        return n;
    endfunction

    assign bit_last  = (cnt == CNT_W'(BIT_CYCLES - 1));
    assign idx_last  = (idx == IDX_W'(FRAME_W - 1));
    // Ready in IDLE, or in the final cycle of the stop bit so frames chain with no idle gap.
    assign din_ready = (state == IDLE) || ((state == STOP) && bit_last);
    assign accept    = din_valid && din_ready;
    assign tx_busy   = (state != IDLE);

    always_comb begin
        state_d = state;
        cnt_d   = bit_last ? '0 : cnt + CNT_W'(1);
        idx_d   = idx;
        case (state)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (accept) state_d = START;
            end
            START: begin
                if (bit_last) state_d = DATA;
            end
            DATA: begin
                if (bit_last) begin
                    if (idx_last) begin
                        idx_d = '0;
`ifdef TXENC_PARITY_EN
                        state_d = PAR;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d = idx + IDX_W'(1);
                    end
                end
            end
`ifdef TXENC_PARITY_EN
            PAR: begin
                if (bit_last) state_d = STOP;
            end
`endif
            STOP: begin
                if (bit_last) state_d = accept ? START : IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // The line bit is registered, so it is derived from the state being entered.
    always_comb begin
        word_d   = accept ? {~ones_count(din), din} : dout_word;
        serial_d = 1'b1;
        case (state_d)
            IDLE:    serial_d = 1'b1;
            START:   serial_d = 1'b0;
            DATA:    serial_d = word_d[idx_d];
`ifdef TXENC_PARITY_EN
            PAR:     serial_d = ^word_d;
`endif
            STOP:    serial_d = 1'b1;
            default: serial_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            dout_word  <= '0;
            dout_valid <= 1'b0;
            tx_serial  <= 1'b1;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            idx        <= idx_d;
            dout_word  <= word_d;
            dout_valid <= accept;
            tx_serial  <= serial_d;
        end
    end

endmodule

// File: tb/tb_tx_frame_encoder.sv
// Directed bench for tx_frame_encoder: vector table plus reset, back-to-back, BIT_CYCLES=3 and 8-bit sequences.
// Parity expectations follow TXENC_PARITY_EN when the bench is compiled with it.
module tb_tx_frame_encoder;

    localparam int FW = 10;
`ifdef TXENC_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- DUTs ----------------
    logic [6:0]  din;
    logic        drv_valid;
    logic        sel;
    logic        a_valid, a_ready, a_dv, a_ser, a_busy;
    logic [9:0]  a_word;
    logic        b_valid, b_ready, b_dv, b_ser, b_busy;
    logic [9:0]  b_word;
    logic [7:0]  c_din;
    logic        c_valid, c_ready, c_dv, c_ser, c_busy;
    logic [11:0] c_word;

    assign a_valid = drv_valid && !sel;
    assign b_valid = drv_valid && sel;

    tx_frame_encoder #(.DATA_W(7), .CSUM_W(3), .BIT_CYCLES(1)) dut_a (
        .clk(clk), .rst(rst), .din(din), .din_valid(a_valid), .din_ready(a_ready),
        .dout_word(a_word), .dout_valid(a_dv), .tx_serial(a_ser), .tx_busy(a_busy));

    tx_frame_encoder #(.DATA_W(7), .CSUM_W(3), .BIT_CYCLES(3)) dut_b (
        .clk(clk), .rst(rst), .din(din), .din_valid(b_valid), .din_ready(b_ready),
        .dout_word(b_word), .dout_valid(b_dv), .tx_serial(b_ser), .tx_busy(b_busy));

    tx_frame_encoder #(.DATA_W(8), .CSUM_W(4), .BIT_CYCLES(1)) dut_c (
        .clk(clk), .rst(rst), .din(c_din), .din_valid(c_valid), .din_ready(c_ready),
        .dout_word(c_word), .dout_valid(c_dv), .tx_serial(c_ser), .tx_busy(c_busy));

    logic       m_ready, m_dv, m_ser, m_busy;
    logic [9:0] m_word;
    assign m_ready = sel ? b_ready : a_ready;
    assign m_dv    = sel ? b_dv    : a_dv;
    assign m_ser   = sel ? b_ser   : a_ser;
    assign m_busy  = sel ? b_busy  : a_busy;
    assign m_word  = sel ? b_word  : a_word;

    // ---------------- scoreboard ----------------
    int checks = 0;
    int passes = 0;
    logic [0:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic push_frame(input logic [9:0] w, input int bc);
        for (int c = 0; c < bc; c++) exp_q.push_back(1'b0);
        for (int i = 0; i < FW; i++)
            for (int c = 0; c < bc; c++) exp_q.push_back(w[i]);
        if (P == 1)
            for (int c = 0; c < bc; c++) exp_q.push_back(^w);
        for (int c = 0; c < bc; c++) exp_q.push_back(1'b1);
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!m_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!m_ready) check("ready_timeout", 32'(m_ready), 32'd1);
    endtask

    task automatic run_frame(input logic [6:0] d, input logic [9:0] w, input int bc);
        int L;
        logic [0:0] b;
        L = (FW + 2 + P) * bc;
        wait_ready();
        din = d;
        drv_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drv_valid = 1'b0;
        check("dout_word", 32'(m_word), 32'(w));
        check("dout_valid_pulse", 32'(m_dv), 32'd1);
        push_frame(w, bc);
        for (int k = 0; k < L; k++) begin
            if (k > 0) begin
                @(negedge clk);
                check($sformatf("dout_valid_low[%0d]", k), 32'(m_dv), 32'd0);
            end
            b = exp_q.pop_front();
            check($sformatf("serial[%0d]", k), 32'(m_ser), 32'(b));
            check($sformatf("busy[%0d]", k), 32'(m_busy), 32'd1);
            check($sformatf("ready[%0d]", k), 32'(m_ready), 32'(k == L - 1));
        end
        @(negedge clk);
        check("busy_end", 32'(m_busy), 32'd0);
        check("serial_idle", 32'(m_ser), 32'd1);
        check("word_held", 32'(m_word), 32'(w));
    endtask

    task automatic run_c(input logic [7:0] d, input logic [11:0] w);
        int n;
        n = 0;
        @(negedge clk);
        while (!c_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!c_ready) check("c_ready_timeout", 32'(c_ready), 32'd1);
        c_din = d;
        c_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        c_valid = 1'b0;
        check("c_dout_word", 32'(c_word), 32'(w));
        check("c_dout_valid", 32'(c_dv), 32'd1);
        check("c_serial_start", 32'(c_ser), 32'd0);
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [6:0] din;
        logic [9:0] word;
    } vec_t;
    vec_t vecs[6];

    initial begin
        logic [0:0] b;
        int L;

        vecs[0] = '{7'b1010011, 10'h1D3};
        vecs[1] = '{7'h00,      10'h380};
        vecs[2] = '{7'h7F,      10'h07F};
        vecs[3] = '{7'h01,      10'h301};
        vecs[4] = '{7'b0101010, 10'h22A};
        vecs[5] = '{7'b1111110, 10'h0FE};

        rst = 1'b1;
        din = '0;
        drv_valid = 1'b0;
        sel = 1'b0;
        c_din = '0;
        c_valid = 1'b0;
        #3;
        check("rst_serial", 32'(a_ser), 32'd1);
        check("rst_ready", 32'(a_ready), 32'd1);
        check("rst_busy", 32'(a_busy), 32'd0);
        check("rst_dout_valid", 32'(a_dv), 32'd0);
        check("rst_dout_word", 32'(a_word), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_frame(vecs[i].din, vecs[i].word, 1);

        // Back-to-back: valid held high, B queued while A is in flight.
        L = FW + 2 + P;
        wait_ready();
        din = vecs[0].din;
        drv_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        din = vecs[4].din;
        push_frame(vecs[0].word, 1);
        push_frame(vecs[4].word, 1);
        for (int k = 0; k < 2 * L; k++) begin
            if (k > 0) @(negedge clk);
            b = exp_q.pop_front();
            check($sformatf("b2b_serial[%0d]", k), 32'(a_ser), 32'(b));
            check($sformatf("b2b_busy[%0d]", k), 32'(a_busy), 32'd1);
            if (k > 0 && k < L) begin
                check($sformatf("b2b_no_early_accept[%0d]", k), 32'(a_dv), 32'd0);
                check($sformatf("b2b_word_a[%0d]", k), 32'(a_word), 32'(vecs[0].word));
            end
            if (k == L) begin
                check("b2b_accept_spacing", 32'(a_dv), 32'd1);
                check("b2b_word_b", 32'(a_word), 32'(vecs[4].word));
                drv_valid = 1'b0;
            end
        end
        @(negedge clk);
        check("b2b_busy_end", 32'(a_busy), 32'd0);

        // Reset in the middle of the data field.
        wait_ready();
        din = 7'h7F;
        drv_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drv_valid = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_serial", 32'(a_ser), 32'd1);
        check("midrst_busy", 32'(a_busy), 32'd0);
        check("midrst_ready", 32'(a_ready), 32'd1);
        check("midrst_dout_valid", 32'(a_dv), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("postrst_idle_serial", 32'(a_ser), 32'd1);
        run_frame(vecs[0].din, vecs[0].word, 1);

        // BIT_CYCLES = 3 instance.
        sel = 1'b1;
        run_frame(vecs[0].din, vecs[0].word, 3);
        run_frame(vecs[3].din, vecs[3].word, 3);
        sel = 1'b0;

        // DATA_W = 8, CSUM_W = 4 instance.
        run_c(8'hFF, 12'h7FF);
        run_c(8'h00, 12'hF00);
        run_c(8'hA5, 12'hBA5);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
